sdfa_cfg_serializer: RTL and testbench
======================================

SDFA_CFG_SERIALIZER -- requirements
Module: sdfa_cfg_serializer

Interface
REQ-001 Parameter M_BITS, default 255, master image length in bits.
REQ-002 Parameter B_BITS, default 171, block image length in bits.
REQ-003 Parameter W, default 16, host word width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rstn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 set_up_req  input  1  downstream request to start configuration load; level-sensitive.
REQ-008 cfg_valid  input  1  host word valid.
REQ-009 cfg_data  input  W  host config word.
REQ-010 cfg_ready  output  1  block accepts cfg_data this cycle.
REQ-011 master_inf_valid  output  1  master serial bit valid.
REQ-012 master_in  output  1  master serial bit.
REQ-013 block_inf_valid  output  1  block serial bit valid.
REQ-014 block_in  output  1  block serial bit.
REQ-015 busy  output  1  high in LOAD_M or LOAD_B.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 States SHALL be IDLE, LOAD_M, LOAD_B and DONE.
REQ-018 IDLE->LOAD_M SHALL occur at the first edge with set_up_req=1; otherwise the FSM stays in IDLE.
REQ-019 A word SHALL be accepted at an edge where cfg_valid&&cfg_ready=1; cfg_valid with cfg_ready=0 SHALL be ignored, with no side effects.
REQ-020 The host stream SHALL be ceil(M_BITS/W)=16 master words followed by ceil(B_BITS/W)=11 block words.
REQ-021 Image bit k SHALL be taken from word k/W, bit k%W (LSB first); master word 15 bit 15 and block word 10 bits 15:11 SHALL be discarded, never emitted.
REQ-022 An accepted word SHALL load a W-bit shift register plus a remaining-bit count: W, or the tail count (15 master / 11 block) for the last word.
REQ-023 The first bit of an accepted word SHALL appear on the serial output in the cycle after acceptance (latency 1).
REQ-024 While the remaining-bit count is >0, the active serial output SHALL show valid=1 with data=shift_reg[0]; each edge SHALL shift right by one and decrement the count.
REQ-025 cfg_ready SHALL be 1 only in LOAD_M/LOAD_B, when the current target's word count < its total and the remaining-bit count <= 1; back-to-back words SHALL therefore stream with no valid gap.
REQ-026 A host stall SHALL drop valid to 0; no bit is emitted or lost.
REQ-027 master_inf_valid and block_inf_valid SHALL never be 1 in the same cycle; block_inf_valid SHALL be 0 in LOAD_M and master_inf_valid SHALL be 0 in LOAD_B.
REQ-028 LOAD_M->LOAD_B SHALL occur at the edge that consumes master bit 254; the first block word SHALL be accepted no earlier than the first LOAD_B cycle.
REQ-029 LOAD_B->DONE SHALL occur at the edge that consumes block bit 170.
REQ-030 DONE SHALL be sticky until rstn, with cfg_ready=0 and both valids 0; set_up_req SHALL be ignored there.
REQ-031 Exactly M_BITS master valids and B_BITS block valids SHALL be emitted per configuration.
REQ-032 serial data SHALL be 0 whenever its valid is 0.
REQ-033 All outputs SHALL be decoded from registers only; cfg_ready SHALL have no combinational path from cfg_valid or cfg_data.
REQ-034 set_up_req falling mid-load SHALL NOT abort the load.

Reset
REQ-035 On rstn=0, all registers and outputs SHALL go to 0 immediately: state=IDLE, counts=0, busy=0, done=0, cfg_ready=0.
REQ-036 Reset mid-load SHALL discard partial data; the next load SHALL restart from master bit 0.

Verification
REQ-037 Reset, set_up_req=1, 27 words back-to-back -> 255 consecutive master valids starting 1 cycle after word 0 is accepted, then 171 block valids, then done=1.
REQ-038 Master word 0 = 16'h0001 -> master_in = 1 on the first valid cycle and 0 on the next 15.
REQ-039 Master word 15 = 16'hFFFF -> exactly 15 ones are emitted; total master valid count = 255.
REQ-040 cfg_valid low for 5 cycles mid-word stream -> valid=0 for those cycles; the bitstream resumes unchanged.
REQ-041 rstn low after 100 master bits -> outputs 0 at once; a full reload is bit-exact.
REQ-042 cfg_valid=1 in IDLE with set_up_req=0, or in DONE -> cfg_ready=0 and no valid asserted.

Source files
------------

// File: rtl/sdfa_cfg_serializer_if.sv
// Host-side word stream plus the two serial configuration outputs of the serializer.
interface sdfa_cfg_serializer_if #(
  parameter int W = 16
);
  logic         set_up_req;
  logic         cfg_valid;
  logic [W-1:0] cfg_data;
  logic         cfg_ready;
  logic         master_inf_valid;
  logic         master_in;
  logic         block_inf_valid;
  logic         block_in;
  logic         busy;
  logic         done;

  modport master (
    output set_up_req, cfg_valid, cfg_data,
    input  cfg_ready, master_inf_valid, master_in, block_inf_valid, block_in, busy, done
  );

  modport slave (
    input  set_up_req, cfg_valid, cfg_data,
    output cfg_ready, master_inf_valid, master_in, block_inf_valid, block_in, busy, done
  );
endinterface

// File: rtl/sdfa_cfg_serializer.sv
// Serializes a host word stream into a master image followed by a block image, LSB first.
// state  | meaning
// IDLE   | waiting for set_up_req
// LOAD_M | accepting master words, shifting master bits out
// LOAD_B | accepting block words, shifting block bits out
// DONE   | both images delivered; sticky until reset
module sdfa_cfg_serializer #(
  parameter int M_BITS = 255,
  parameter int B_BITS = 171,
  parameter int W      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  sdfa_cfg_serializer_if.slave bus
);

  localparam int M_WORDS = (M_BITS + W - 1) / W;
  localparam int B_WORDS = (B_BITS + W - 1) / W;
  localparam int M_TAIL  = M_BITS - (M_WORDS - 1) * W;
  localparam int B_TAIL  = B_BITS - (B_WORDS - 1) * W;
  localparam int MAX_WORDS = (M_WORDS > B_WORDS) ? M_WORDS : B_WORDS;
  localparam int WC_W    = $clog2(MAX_WORDS + 1);
  localparam int RC_W    = $clog2(W + 1);

  localparam logic [WC_W-1:0] M_WORDS_C = WC_W'(M_WORDS);
  localparam logic [WC_W-1:0] B_WORDS_C = WC_W'(B_WORDS);
  localparam logic [WC_W-1:0] M_LAST_C  = WC_W'(M_WORDS - 1);
  localparam logic [WC_W-1:0] B_LAST_C  = WC_W'(B_WORDS - 1);
  localparam logic [RC_W-1:0] W_C       = RC_W'(W);
  localparam logic [RC_W-1:0] M_TAIL_C  = RC_W'(M_TAIL);
  localparam logic [RC_W-1:0] B_TAIL_C  = RC_W'(B_TAIL);
  localparam logic [RC_W-1:0] ONE_C     = RC_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_M = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [RC_W-1:0] rem_q, rem_d;

  logic in_load;
  logic in_m;
  logic words_left;
  logic last_word;
  logic last_bit;
  logic ready;
  logic accept;

  // One word counter serves whichever image is active; it is cleared on the M->B hand-over.
  assign in_m       = (state_q == LOAD_M);
  assign in_load    = in_m || (state_q == LOAD_B);
  assign words_left = in_m ? (wcnt_q < M_WORDS_C) : (wcnt_q < B_WORDS_C);
  assign last_word  = in_m ? (wcnt_q == M_LAST_C) : (wcnt_q == B_LAST_C);
  assign last_bit   = in_load && !words_left && (rem_q == ONE_C);
  assign ready      = in_load && words_left && (rem_q <= ONE_C);
  assign accept     = ready && bus.cfg_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      sreg_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.set_up_req) begin
          state_d = LOAD_M;
          wcnt_d  = '0;
          sreg_d  = '0;
          rem_d   = '0;
        end
      end
      LOAD_M, LOAD_B: begin
        // Loading on rem==1 overwrites the final bit only after it has been shown this cycle.
        if (accept) begin
          sreg_d = bus.cfg_data;
          rem_d  = last_word ? (in_m ? M_TAIL_C : B_TAIL_C) : W_C;
          wcnt_d = wcnt_q + WC_W'(1);
        end else if (rem_q != '0) begin
          sreg_d = sreg_q >> 1;
          rem_d  = rem_q - ONE_C;
        end
        if (last_bit) begin
          state_d = in_m ? LOAD_B : DONE;
          wcnt_d  = '0;
          sreg_d  = '0;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cfg_ready        = ready;
  assign bus.master_inf_valid = in_m && (rem_q != '0);
  assign bus.master_in        = bus.master_inf_valid && sreg_q[0];
  assign bus.block_inf_valid  = (state_q == LOAD_B) && (rem_q != '0);
  assign bus.block_in         = bus.block_inf_valid && sreg_q[0];
  assign bus.busy             = in_load;
  assign bus.done             = (state_q == DONE);

endmodule

// File: tb/tb_sdfa_cfg_serializer.sv
// Bench for sdfa_cfg_serializer: table-driven image loads, directed stall/reset cases, random loads.
module tb_sdfa_cfg_serializer;

  localparam int M_BITS = 255;
  localparam int B_BITS = 171;
  localparam int W      = 16;
  localparam int NW     = 27;
  localparam int NMW    = 16;

  logic clk;
  logic rstn;

  sdfa_cfg_serializer_if #(.W(W)) bus ();

  sdfa_cfg_serializer #(.M_BITS(M_BITS), .B_BITS(B_BITS), .W(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [W-1:0]      words_a [NW];
  int                stall_a [NW];
  logic [M_BITS-1:0] got_m, exp_m;
  logic [B_BITS-1:0] got_b, exp_b;
  int m_cnt, b_cnt, m_first, m_last, b_first, b_last, m_gap, b_gap;
  int done_cyc, acc0_cyc, viol;

  typedef struct {
    string       name;
    logic [15:0] m0;
    logic [15:0] m15;
    logic [15:0] b10;
    logic [15:0] exp_first16;
    int          exp_m_tail_ones;
    logic [10:0] exp_b_tail;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    bus.set_up_req = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_data   = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Image bit k comes from word k/W, bit k%W; block words follow the master words.
  task automatic build_expected();
    for (int k = 0; k < M_BITS; k++) exp_m[k] = words_a[k / W][k % W];
    for (int k = 0; k < B_BITS; k++) exp_b[k] = words_a[NMW + k / W][k % W];
  endtask

  task automatic run_load(input int junk, input int drop_req_at, input int abort_at);
    int idx;
    int stall_left;
    int cyc;
    idx = 0; stall_left = stall_a[0]; cyc = 0;
    m_cnt = 0; b_cnt = 0; m_first = -1; m_last = -1; b_first = -1; b_last = -1;
    m_gap = 0; b_gap = 0; done_cyc = -1; acc0_cyc = -1; viol = 0;
    got_m = '0; got_b = '0;
    bus.set_up_req = 1'b1;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.master_inf_valid) begin
        if (m_cnt < M_BITS) got_m[m_cnt] = bus.master_in;
        if (m_first < 0) m_first = cyc;
        else m_gap += cyc - m_last - 1;
        m_last = cyc;
        m_cnt++;
      end
      if (bus.block_inf_valid) begin
        if (b_cnt < B_BITS) got_b[b_cnt] = bus.block_in;
        if (b_first < 0) b_first = cyc;
        else b_gap += cyc - b_last - 1;
        b_last = cyc;
        b_cnt++;
      end
      if (bus.master_inf_valid && bus.block_inf_valid) viol++;
      if (!bus.master_inf_valid && bus.master_in) viol++;
      if (!bus.block_inf_valid && bus.block_in) viol++;
      if (bus.cfg_ready && !bus.busy) viol++;
      if (bus.busy && bus.done) viol++;
      if (bus.master_inf_valid && b_cnt > 0) viol++;
      if (bus.block_inf_valid && m_cnt < M_BITS) viol++;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at > 0 && m_cnt == abort_at) break;
      if (cyc == drop_req_at) bus.set_up_req = 1'b0;
      if (idx < NW) begin
        if (stall_left > 0) begin
          bus.cfg_data = W'($urandom);
          if (bus.cfg_ready) begin
            bus.cfg_valid = 1'b0;
            stall_left--;
          end else begin
            bus.cfg_valid = (junk != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end else begin
          bus.cfg_valid = 1'b1;
          bus.cfg_data  = words_a[idx];
          if (bus.cfg_ready) begin
            if (idx == 0) acc0_cyc = cyc;
            idx++;
            if (idx < NW) stall_left = stall_a[idx];
          end
        end
      end else begin
        bus.cfg_data  = W'($urandom);
        bus.cfg_valid = (!bus.cfg_ready && junk != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic check_load(input string tag, input int exp_m_gap, input bit tight);
    check({tag, ".done_reached"}, 512'(done_cyc >= 0), 512'(1));
    check({tag, ".m_count"}, 512'(m_cnt), 512'(M_BITS));
    check({tag, ".b_count"}, 512'(b_cnt), 512'(B_BITS));
    check({tag, ".m_bits"}, 512'(got_m), 512'(exp_m));
    check({tag, ".b_bits"}, 512'(got_b), 512'(exp_b));
    check({tag, ".latency"}, 512'(m_first), 512'(acc0_cyc + 1));
    check({tag, ".protocol"}, 512'(viol), 512'(0));
    check({tag, ".done_after_last"}, 512'(done_cyc), 512'(b_last + 1));
    if (tight) begin
      check({tag, ".m_gap"}, 512'(m_gap), 512'(exp_m_gap));
      check({tag, ".b_gap"}, 512'(b_gap), 512'(0));
      check({tag, ".m_to_b"}, 512'(b_first), 512'(m_last + 2));
    end else begin
      check({tag, ".b_after_m"}, 512'(b_first > m_last), 512'(1));
    end
  endtask

  // Drives cfg_valid with junk for n cycles; nothing may move.
  task automatic hold_quiet(input string tag, input int n, input logic exp_done, input bit toggle_req);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.cfg_valid  = 1'b1;
      bus.cfg_data   = W'($urandom);
      bus.set_up_req = toggle_req ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (bus.cfg_ready || bus.master_inf_valid || bus.block_inf_valid || bus.busy ||
          bus.master_in || bus.block_in || (bus.done !== exp_done)) bad++;
    end
    bus.cfg_valid  = 1'b0;
    bus.set_up_req = 1'b0;
    check({tag, ".quiet"}, 512'(bad), 512'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, 512'(bus.cfg_ready), 512'(0));
    check({tag, ".busy"}, 512'(bus.busy), 512'(0));
    check({tag, ".done"}, 512'(bus.done), 512'(0));
    check({tag, ".valids"}, 512'({bus.master_inf_valid, bus.block_inf_valid}), 512'(0));
    check({tag, ".data"}, 512'({bus.master_in, bus.block_in}), 512'(0));
  endtask

  task automatic random_words();
    for (int i = 0; i < NW; i++) begin
      words_a[i] = W'($urandom);
      stall_a[i] = 0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{"m0_lsb", 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 15, 11'h7FF};
    tbl[1] = '{"m0_msb", 16'h8000, 16'h8000, 16'hF800, 16'h8000, 0,  11'h000};
    tbl[2] = '{"alt",    16'hAAAA, 16'h7FFF, 16'h07FF, 16'hAAAA, 15, 11'h7FF};
    tbl[3] = '{"mix",    16'h1234, 16'h0F0F, 16'h0403, 16'h1234, 8,  11'h403};

    rstn           = 1'b0;
    bus.set_up_req = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_data   = '0;
    #3;
    check_all_zero("reset");
    do_reset();

    hold_quiet("idle", 10, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      random_words();
      words_a[0]  = tbl[t].m0;
      words_a[15] = tbl[t].m15;
      words_a[26] = tbl[t].b10;
      build_expected();
      run_load(0, 0, 0);
      check_load(tbl[t].name, 0, 1'b1);
      check({tbl[t].name, ".first16"}, 512'(got_m[15:0]), 512'(tbl[t].exp_first16));
      check({tbl[t].name, ".m_tail_ones"}, 512'($countones(got_m[254:240])), 512'(tbl[t].exp_m_tail_ones));
      check({tbl[t].name, ".b_tail"}, 512'(got_b[170:160]), 512'(tbl[t].exp_b_tail));
      if (t == 0) hold_quiet("done_sticky", 12, 1'b1, 1'b1);
    end

    do_reset();
    random_words();
    stall_a[8] = 5;
    build_expected();
    run_load(0, 0, 0);
    check_load("stall5", 5, 1'b1);

    do_reset();
    random_words();
    run_load(0, 0, 100);
    check("abort.m_count", 512'(m_cnt), 512'(100));
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    random_words();
    build_expected();
    run_load(0, 0, 0);
    check_load("reload", 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      random_words();
      for (int i = 0; i < NW; i++)
        stall_a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      build_expected();
      run_load(1, int'($urandom_range(2, 300)), 0);
      check_load($sformatf("rand%0d", r), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
